// File: rtl/mem_if_pkg.sv
// Shared definitions for the processor-side master of the slot-based BRAM port.
// Holds the state encodings and default slot timing.
package mem_if_pkg;

  localparam int SLOT_CYCLES_DEF   = 4;
  localparam int ADVANCE_PHASE_DEF = 1;
  localparam int CAPTURE_PHASE_DEF = 3;
  localparam int MAX_INST          = 28;

  typedef enum logic [3:0] {
    M_START,
    M_IDLE,
    M_ENTER_INST,
    M_FETCH,
    M_ARM_B,
    M_LOAD,
    M_ARM_P,
    M_STORE,
    M_FLUSH
  } m_state_t;

  typedef enum logic {
    PEER_IDLE,
    PEER_INST
  } peer_mode_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } op_t;

endpackage

// File: rtl/mem_port_master_slot_timer.sv
// Free-running slot phase counter; strobes are high during the cycle whose
// ending clk edge is the named phase edge.
module slot_timer #(
  parameter int SLOT_CYCLES   = 4,
  parameter int ADVANCE_PHASE = 1,
  parameter int CAPTURE_PHASE = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic boundary,
  output logic update,
  output logic capture
);

  localparam int PW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase == PW'(SLOT_CYCLES - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign boundary = (phase == PW'(ADVANCE_PHASE));
  assign update   = (phase == PW'(SLOT_CYCLES - 1));
  assign capture  = (phase == PW'(CAPTURE_PHASE));

endmodule

// File: rtl/mem_port_master.sv
// Processor-side initiator: turns fetch/load/store pulses into the responder's
// slot protocol while tracking the responder's IDLE/INST mode.
module mem_port_master
  import mem_if_pkg::*;
#(
  parameter int SLOT_CYCLES   = SLOT_CYCLES_DEF,
  parameter int ADVANCE_PHASE = ADVANCE_PHASE_DEF,
  parameter int CAPTURE_PHASE = CAPTURE_PHASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_pc,
  input  logic        load_req,
  input  logic [7:0]  load_idx,
  input  logic        store_req,
  input  logic [7:0]  store_idx,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  inst_out,
  output logic [31:0] load_data,
  output logic        r_inst,
  output logic        r_bram,
  output logic        r_processor,
  output logic [7:0]  address_out,
  output logic [7:0]  wr_byte,
  input  logic [7:0]  rd_byte
);

  logic       boundary;
  logic       update;
  logic       capture;
  m_state_t   state;
  peer_mode_t peer_mode;
  op_t        op;
  logic [7:0]  idx;
  logic [31:0] data;
  logic [1:0]  k;
  logic [2:0]  flush_cnt;
  logic [23:0] lo_bytes;

  slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .ADVANCE_PHASE(ADVANCE_PHASE),
    .CAPTURE_PHASE(CAPTURE_PHASE)
  ) u_slot_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .boundary(boundary),
    .update  (update),
    .capture (capture)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= M_START;
      peer_mode   <= PEER_IDLE;
      op          <= OP_FETCH;
      idx         <= '0;
      data        <= '0;
      k           <= '0;
      flush_cnt   <= '0;
      lo_bytes    <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      inst_out    <= '0;
      load_data   <= '0;
      r_inst      <= 1'b0;
      r_bram      <= 1'b0;
      r_processor <= 1'b0;
      address_out <= '0;
      wr_byte     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        M_START: begin
          // The responder leaves its start state at the first boundary.
          if (boundary) begin
            state <= M_IDLE;
            busy  <= 1'b0;
          end
        end
        M_IDLE: begin
          if (!busy) begin
            if (store_req) begin
              op <= OP_STORE; idx <= store_idx; data <= store_data; busy <= 1'b1;
            end else if (load_req) begin
              op <= OP_LOAD; idx <= load_idx; busy <= 1'b1;
            end else if (fetch_req) begin
              op <= OP_FETCH; idx <= fetch_pc; busy <= 1'b1;
            end
          end else if (update) begin
            // Accepted request waits here so request lines only move at slot starts.
            k         <= '0;
            flush_cnt <= '0;
            case (op)
              OP_STORE: begin
                if (peer_mode == PEER_INST) begin
                  state <= M_FLUSH; r_bram <= 1'b1; address_out <= '0;
                end else begin
                  state <= M_ARM_P; r_processor <= 1'b1; address_out <= idx;
                end
              end
              OP_LOAD: begin
                address_out <= idx;
                if (peer_mode == PEER_INST) begin
                  state <= M_ARM_B; r_bram <= 1'b1;
                end else begin
                  state <= M_ENTER_INST; r_inst <= 1'b1;
                end
              end
              default: begin
                address_out <= idx;
                if (peer_mode == PEER_INST) begin
                  state <= M_FETCH;
                end else begin
                  state <= M_ENTER_INST; r_inst <= 1'b1;
                end
              end
            endcase
          end
        end
        M_ENTER_INST: begin
          if (update) begin
            r_inst    <= 1'b0;
            peer_mode <= PEER_INST;
            if (op == OP_LOAD) begin
              state <= M_ARM_B; r_bram <= 1'b1;
            end else begin
              state <= M_FETCH;
            end
          end
        end
        M_FETCH: begin
          if (capture) inst_out <= rd_byte;
          if (update) begin
            state <= M_IDLE; busy <= 1'b0; done <= 1'b1;
          end
        end
        M_ARM_B: begin
          if (update) begin
            r_bram <= 1'b0; state <= M_LOAD; k <= '0;
          end
        end
        M_LOAD: begin
          // Last byte goes straight into load_data so the word changes in one step.
          if (capture) begin
            case (k)
              2'd0:    lo_bytes[7:0]   <= rd_byte;
              2'd1:    lo_bytes[15:8]  <= rd_byte;
              2'd2:    lo_bytes[23:16] <= rd_byte;
              default: load_data       <= {rd_byte, lo_bytes};
            endcase
          end
          if (update) begin
            if (k == 2'd3) begin
              peer_mode <= PEER_IDLE;
              state <= M_IDLE; busy <= 1'b0; done <= 1'b1;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        M_FLUSH: begin
          if (update) begin
            r_bram <= 1'b0;
            if (flush_cnt == 3'd4) begin
              peer_mode <= PEER_IDLE;
              state <= M_ARM_P; r_processor <= 1'b1; address_out <= idx;
            end else begin
              flush_cnt <= flush_cnt + 3'd1;
            end
          end
        end
        M_ARM_P: begin
          if (update) begin
            r_processor <= 1'b0; state <= M_STORE; k <= '0; wr_byte <= data[7:0];
          end
        end
        M_STORE: begin
          if (update) begin
            if (k == 2'd3) begin
              state <= M_IDLE; busy <= 1'b0; done <= 1'b1;
            end else begin
              k       <= k + 2'd1;
              wr_byte <= data[{k + 2'd1, 3'b000} +: 8];
            end
          end
        end
        default: begin
          state <= M_IDLE; busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master with a behavioural slot responder and BRAM model.
module tb_mem_port_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_pc = '0;
  logic        load_req = 1'b0;
  logic [7:0]  load_idx = '0;
  logic        store_req = 1'b0;
  logic [7:0]  store_idx = '0;
  logic [31:0] store_data = '0;
  logic        busy;
  logic        done;
  logic [7:0]  inst_out;
  logic [31:0] load_data;
  logic        r_inst;
  logic        r_bram;
  logic        r_processor;
  logic [7:0]  address_out;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef enum logic [2:0] {R_START, R_IDLE, R_INST, R_RD, R_WR} r_state_t;
  r_state_t   rs;
  int         ph;
  int         rcnt;
  int         rbase;
  logic [7:0] bram [0:255];

  int inst_hi = 0;
  int bram_hi = 0;
  int proc_hi = 0;
  int done_cnt = 0;

  mem_port_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .load_req   (load_req),
    .load_idx   (load_idx),
    .store_req  (store_req),
    .store_idx  (store_idx),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .inst_out   (inst_out),
    .load_data  (load_data),
    .r_inst     (r_inst),
    .r_bram     (r_bram),
    .r_processor(r_processor),
    .address_out(address_out),
    .wr_byte    (wr_byte),
    .rd_byte    (rd_byte)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responder model: samples requests and moves one step per boundary.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; rs <= R_START; rcnt <= 0; rbase <= 0; rd_byte <= 8'h00;
    end else begin
      ph <= (ph == 3) ? 0 : ph + 1;
      if (ph == 1) begin
        check("proto", 32'(({r_inst, r_bram, r_processor} == 3'b000) ||
                           (rs == R_IDLE && (r_inst ^ r_processor) && !r_bram) ||
                           (rs == R_INST && r_bram && !r_inst && !r_processor)), 32'd1);
        case (rs)
          R_START: rs <= R_IDLE;
          R_IDLE: begin
            if (r_inst) rs <= R_INST;
            else if (r_processor) begin
              rs <= R_WR; rbase <= 140 + 4 * int'(address_out); rcnt <= 0;
            end
          end
          R_INST: begin
            if (r_bram) begin
              rs <= R_RD; rbase <= 28 + 4 * int'(address_out); rcnt <= 0;
            end else begin
              rd_byte <= bram[address_out];
            end
          end
          R_RD: begin
            rd_byte <= bram[(rbase + rcnt) & 255];
            rcnt <= rcnt + 1;
            if (rcnt == 3) rs <= R_IDLE;
          end
          R_WR: begin
            bram[(rbase + rcnt) & 255] <= wr_byte;
            rcnt <= rcnt + 1;
            if (rcnt == 3) rs <= R_IDLE;
          end
          default: rs <= R_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (r_inst) inst_hi <= inst_hi + 1;
    if (r_bram) bram_hi <= bram_hi + 1;
    if (r_processor) proc_hi <= proc_hi + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic reset_checks(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " inst_out"}, 32'(inst_out), 32'd0);
    check({tag, " load_data"}, load_data, 32'd0);
    check({tag, " req_lines"}, 32'({r_inst, r_bram, r_processor}), 32'd0);
    check({tag, " address_out"}, 32'(address_out), 32'd0);
    check({tag, " wr_byte"}, 32'(wr_byte), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    check({tag, " idle_wait"}, 32'(busy), 32'd0);
  endtask

  // mask = {store, load, fetch}; kind selects which result to score (0 fetch, 1 load, 2 store).
  task automatic do_op(input string tag, input logic [2:0] mask, input int kind,
                       input logic [7:0] a, input logic [31:0] d, input logic [31:0] expv,
                       input int slots, input int e_inst, input int e_bram, input int e_proc,
                       input bit poke);
    int cyc;
    int lim;
    int i0, b0, p0, d0, b;
    logic [31:0] exp_word;
    logic [31:0] obs;
    wait_idle(tag);
    i0 = inst_hi; b0 = bram_hi; p0 = proc_hi; d0 = done_cnt;
    fetch_pc = a; load_idx = a; store_idx = a; store_data = d;
    fetch_req = mask[0]; load_req = mask[1]; store_req = mask[2];
    exp_q.push_back(expv);
    @(negedge clk);
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
    cyc = 1;
    lim = 4 * slots + 40;
    if (poke) begin
      fetch_req = 1'b1; fetch_pc = 8'd9;
    end
    while (done !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      fetch_req = 1'b0;
      cyc++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_clear"}, 32'(busy), 32'd0);
    check({tag, " latency_ok"}, 32'(cyc >= 4 * slots + 2 && cyc <= 4 * slots + 5), 32'd1);
    exp_word = exp_q.pop_front();
    b = (140 + 4 * int'(a)) & 255;
    if (kind == 0) obs = 32'(inst_out);
    else if (kind == 1) obs = load_data;
    else obs = {bram[b + 3], bram[b + 2], bram[b + 1], bram[b]};
    check({tag, " result"}, obs, exp_word);
    check({tag, " peer"}, 32'(rs), (kind == 0) ? 32'(R_INST) : 32'(R_IDLE));
    if (kind == 0) check({tag, " address_hold"}, 32'(address_out), 32'(a));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " r_inst_cycles"}, 32'(inst_hi - i0), 32'(4 * e_inst));
    check({tag, " r_bram_cycles"}, 32'(bram_hi - b0), 32'(4 * e_bram));
    check({tag, " r_proc_cycles"}, 32'(proc_hi - p0), 32'(4 * e_proc));
  endtask

  initial begin
    logic [7:0]  ridx;
    logic [31:0] rword;
    logic [31:0] d3;
    int n;
    for (int i = 0; i < 256; i++) bram[i] = 8'($urandom_range(0, 255));
    bram[0] = 8'h5C;
    bram[5] = 8'hA3;
    bram[7] = 8'h6E;
    bram[36] = 8'h11; bram[37] = 8'h22; bram[38] = 8'h33; bram[39] = 8'h44;

    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("startup busy", 32'(busy), 32'd1);

    do_op("fetch5", 3'b001, 0, 8'd5, 32'd0, 32'h0000_00A3, 2, 1, 0, 0, 1'b0);
    do_op("load2_inst", 3'b010, 1, 8'd2, 32'd0, 32'h4433_2211, 5, 0, 1, 0, 1'b0);
    do_op("store1_idle", 3'b100, 2, 8'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 0, 0, 1, 1'b0);
    check("store1 byte144", 32'(bram[144]), 32'h0000_00EF);

    do_op("fetch7", 3'b001, 0, 8'd7, 32'd0, 32'h0000_006E, 2, 1, 0, 0, 1'b0);
    do_op("store0_flush", 3'b100, 2, 8'd0, 32'h0102_0304, 32'h0102_0304, 10, 0, 1, 1, 1'b0);
    check("flush keeps load_data", load_data, 32'h4433_2211);

    d3 = $urandom();
    do_op("all3_poke", 3'b111, 2, 8'd3, d3, d3, 5, 0, 0, 1, 1'b1);
    check("all3 inst_out kept", 32'(inst_out), 32'h0000_006E);
    check("all3 load_data kept", load_data, 32'h4433_2211);

    ridx = 8'($urandom_range(3, 10));
    for (int j = 0; j < 4; j++) bram[28 + 4 * int'(ridx) + j] = 8'($urandom_range(0, 255));
    rword = {bram[28 + 4 * int'(ridx) + 3], bram[28 + 4 * int'(ridx) + 2],
             bram[28 + 4 * int'(ridx) + 1], bram[28 + 4 * int'(ridx)]};
    do_op("load_rand_idle", 3'b010, 1, ridx, 32'd0, rword, 6, 1, 1, 0, 1'b0);

    // Reset in the middle of a load's third byte slot.
    wait_idle("mid_reset");
    load_idx = 8'd2; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    n = 0;
    while (r_bram !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    while (r_bram !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("mid_reset reached load", 32'(n < 100), 32'd1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("fetch0_after_reset", 3'b001, 0, 8'd0, 32'd0, 32'h0000_005C, 2, 1, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Processor-side initiator for the slot-based BRAM interface block.
- Converts single-cycle fetch/load/store requests into that block's slot protocol:
  - drives r_inst, r_bram and r_processor with an index address;
  - assembles 4 returned bytes into a 32-bit load word;
  - serialises a 32-bit store word into 4 bytes.
- Mirrors the responder's mode (IDLE / INST) internally so every request sequence is legal.

Parameters:
- SLOT_CYCLES, 4: clk cycles per responder slot; the responder advances state once per slot.
- ADVANCE_PHASE, 1: slot phase value at whose ending clk edge the responder samples requests and changes state.
- CAPTURE_PHASE, 3: slot phase at whose ending edge a returned byte is captured.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset; shared with responder
- fetch_req  in  1  one-cycle pulse, fetch instruction byte at fetch_pc
- fetch_pc  in  8  instruction address
- load_req  in  1  one-cycle pulse, load data word load_idx
- load_idx  in  8  data word index
- store_req  in  1  one-cycle pulse, store store_data to word store_idx
- store_idx  in  8  store word index
- store_data  in  32  store word, byte0 = [7:0]
- busy  out  1  operation in progress; requests ignored while high
- done  out  1  one-cycle pulse at completion
- inst_out  out  8  last fetched instruction byte
- load_data  out  32  last loaded word
- r_inst  out  1  to responder r_inst
- r_bram  out  1  to responder r_bram
- r_processor  out  1  to responder r_processor
- address_out  out  8  to responder address_in (pc or index)
- wr_byte  out  8  to responder p_data_in (store byte)
- rd_byte  in  8  from responder p_data_out (instruction/load byte)

Behaviour:
- Clock, reset and phase
  - Reset is rst_n, asynchronous, active-low; clock is clk.
  - Phase counter 0..SLOT_CYCLES-1, reset 0, free-running, wraps to 0.
  - A "boundary" is the clk edge ending phase ADVANCE_PHASE.
  - Request outputs change only on the edge ending phase SLOT_CYCLES-1, so they are stable across the boundary.
  - rd_byte is captured only on the edge ending CAPTURE_PHASE.
- Reset values: busy=1, done=0, inst_out=0, load_data=0, r_inst=r_bram=r_processor=0, address_out=0, wr_byte=0, peer_mode=IDLE.
- Startup: busy stays 1 until the first boundary has passed (responder start state), then 0.
- Request acceptance: sampled only when busy=0. Priority store > load > fetch. busy=1 on the next clk. Losers are dropped. The accepted index/pc/data are registered.
- States: M_START, M_IDLE, M_ENTER_INST, M_FETCH, M_ARM_B, M_LOAD, M_ARM_P, M_STORE, M_FLUSH.
- Fetch
  - If peer_mode=IDLE: M_ENTER_INST drives r_inst=1 and address=pc across one boundary, then sets peer_mode=INST.
  - Then M_FETCH: r_inst=0, address=pc held for one full slot; inst_out captured at CAPTURE_PHASE.
  - done pulses; peer_mode stays INST; address_out keeps pc.
- Load
  - If peer_mode=IDLE: do M_ENTER_INST first, with address=idx.
  - M_ARM_B: r_bram=1, address=idx across one boundary.
  - M_LOAD: 4 slots with r_bram=0. Slot k captures byte k into load_data[8k+7:8k], in little-endian order.
  - At the end: peer_mode=IDLE, done pulses, and load_data updates atomically.
- Store
  - Requires peer_mode=IDLE.
  - If peer_mode=INST: first do M_FLUSH, a discard load of index 0 (M_ARM_B + 4 slots). load_data is unchanged and done is not pulsed.
  - M_ARM_P: r_processor=1, r_inst=0, address=idx across one boundary.
  - M_STORE: 4 slots with r_processor=0 and wr_byte = store_data byte k in slot k.
  - done pulses; peer_mode=IDLE.
- Request-line rules: at most one of r_inst/r_bram/r_processor is high at any time. Each is high for exactly one slot.
- Latency, peer IDLE: fetch 2 slots, load 6 slots, store 5 slots.
- Latency, peer INST: fetch 1 slot, load 5 slots, store 10 slots.
- Reset mid-operation: all registers return to reset values. The responder resets simultaneously, so no partial sequence is resumed.
- Requests arriving while busy=1 are ignored and are not queued.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encoding;
  - SLOT_CYCLES, ADVANCE_PHASE and CAPTURE_PHASE defaults;
  - MAX_INST = 28, for bench address checking.
- One sub-module: slot_timer (phase counter emitting boundary, update and capture strobes).

Test Plan:
- Release reset, fetch_req pc=5 with BRAM[5]=0xA3 -> busy for 2 slots after startup, inst_out=0xA3, done once, peer ends in rw_inst.
- From INST mode, load_req idx=2 with BRAM[36..39]=11,22,33,44 -> r_bram for one slot, load_data=0x44332211 after 5 slots, peer idle.
- From IDLE, store_req idx=1 data=0xDEADBEEF -> BRAM[144..147]=EF,BE,AD,DE, r_processor for one slot, done after 5 slots.
- After a fetch (INST), store_req idx=0 data=0x01020304 -> flush load of index 0 with no done pulse, then BRAM[140..143]=04,03,02,01, exactly one done.
- Same-cycle fetch_req+load_req+store_req, then fetch_req while busy -> only the store executes, the later fetch is ignored, exactly one done.
- Assert rst_n low mid-load (slot 2) -> all outputs at reset values immediately; after release a fetch pc=0 completes correctly.
